// File: rtl/vi_mem_arbiter.sv
// Core-side memory port arbiter: grants store-buffer writes and icache/dcache line
// fills onto the single memory request/response interface, with read retry on timeout.
module vi_mem_arbiter #(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk_i,
    input  logic         rsn_i,

    input  logic         ic_req_i,
    input  logic [19:0]  ic_addr_i,
    input  logic         dc_req_i,
    input  logic [19:0]  dc_addr_i,
    input  logic         wr_req_i,
    input  logic [19:0]  wr_addr_i,
    input  logic [31:0]  wr_data_i,
    input  logic         wr_byte_i,

    output logic         ic_valid_o,
    output logic [127:0] ic_data_o,
    output logic         dc_valid_o,
    output logic [127:0] dc_data_o,
    output logic         wr_ack_o,

    input  logic         mem_data_ready_i,
    input  logic [127:0] mem_data_i,
    input  logic [19:0]  mem_addr_i,
    output logic         mem_read_o,
    output logic [19:0]  mem_read_addr_o,
    output logic         mem_write_enable_o,
    output logic         mem_write_byte_o,
    output logic [19:0]  mem_write_addr_o,
    output logic [31:0]  mem_write_data_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR
    } arbState_e;

    arbState_e      state_q, state_d;
    logic [SW-1:0]  starveCnt_q, starveCnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           rdIsIc_q, rdIsIc_d;
    logic [15:0]    lineAddr_q, lineAddr_d;

    logic           icValid_q, icValid_d;
    logic [127:0]   icData_q, icData_d;
    logic           dcValid_q, dcValid_d;
    logic [127:0]   dcData_q, dcData_d;
    logic           wrAck_q, wrAck_d;
    logic           memRead_q, memRead_d;
    logic [19:0]    memReadAddr_q, memReadAddr_d;
    logic           memWe_q, memWe_d;
    logic           memWByte_q, memWByte_d;
    logic [19:0]    memWAddr_q, memWAddr_d;
    logic [31:0]    memWData_q, memWData_d;

    logic           grantWr, grantIc, grantDc;
    logic [15:0]    grantLine;
    logic           respMatch;

    // Only the line part of fill addresses and response addresses is meaningful.
    logic           unusedLowBits;
    assign unusedLowBits = ^{ic_addr_i[3:0], dc_addr_i[3:0], mem_addr_i[3:0]};

    assign respMatch = mem_data_ready_i && (mem_addr_i[19:4] == lineAddr_q);
    assign grantLine = grantIc ? ic_addr_i[19:4] : dc_addr_i[19:4];

    always_comb begin
        grantWr = 1'b0;
        grantIc = 1'b0;
        grantDc = 1'b0;
        if (state_q == IDLE) begin
            if (wr_req_i) begin
                grantWr = 1'b1;
            end else if (ic_req_i && (starveCnt_q == SW'(STARVE_MAX))) begin
                grantIc = 1'b1;
            end else if (dc_req_i) begin
                grantDc = 1'b1;
            end else if (ic_req_i) begin
                grantIc = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        starveCnt_d   = starveCnt_q;
        timer_d       = timer_q;
        rdIsIc_d      = rdIsIc_q;
        lineAddr_d    = lineAddr_q;
        icValid_d     = 1'b0;
        icData_d      = icData_q;
        dcValid_d     = 1'b0;
        dcData_d      = dcData_q;
        wrAck_d       = 1'b0;
        memRead_d     = 1'b0;
        memReadAddr_d = memReadAddr_q;
        memWe_d       = 1'b0;
        memWByte_d    = memWByte_q;
        memWAddr_d    = memWAddr_q;
        memWData_d    = memWData_q;

        // Writes also count as grants that bypass a waiting icache.
        if (!ic_req_i || grantIc) begin
            starveCnt_d = '0;
        end else if ((grantWr || grantDc) && (starveCnt_q < SW'(STARVE_MAX))) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (grantWr) begin
                    state_d    = WR;
                    memWe_d    = 1'b1;
                    wrAck_d    = 1'b1;
                    memWByte_d = wr_byte_i;
                    memWAddr_d = wr_addr_i;
                    memWData_d = wr_data_i;
                end else if (grantIc || grantDc) begin
                    state_d       = RD_REQ;
                    rdIsIc_d      = grantIc;
                    lineAddr_d    = grantLine;
                    memRead_d     = 1'b1;
                    memReadAddr_d = {grantLine, 4'h0};
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
                timer_d = '0;
            end
            RD_WAIT: begin
                if (respMatch) begin
                    state_d = IDLE;
                    if (rdIsIc_q) begin
                        icValid_d = 1'b1;
                        icData_d  = mem_data_i;
                    end else begin
                        dcValid_d = 1'b1;
                        dcData_d  = mem_data_i;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d   = RD_REQ;
                    memRead_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q       <= IDLE;
            starveCnt_q   <= '0;
            timer_q       <= '0;
            rdIsIc_q      <= 1'b0;
            lineAddr_q    <= '0;
            icValid_q     <= 1'b0;
            icData_q      <= '0;
            dcValid_q     <= 1'b0;
            dcData_q      <= '0;
            wrAck_q       <= 1'b0;
            memRead_q     <= 1'b0;
            memReadAddr_q <= '0;
            memWe_q       <= 1'b0;
            memWByte_q    <= 1'b0;
            memWAddr_q    <= '0;
            memWData_q    <= '0;
        end else begin
            state_q       <= state_d;
            starveCnt_q   <= starveCnt_d;
            timer_q       <= timer_d;
            rdIsIc_q      <= rdIsIc_d;
            lineAddr_q    <= lineAddr_d;
            icValid_q     <= icValid_d;
            icData_q      <= icData_d;
            dcValid_q     <= dcValid_d;
            dcData_q      <= dcData_d;
            wrAck_q       <= wrAck_d;
            memRead_q     <= memRead_d;
            memReadAddr_q <= memReadAddr_d;
            memWe_q       <= memWe_d;
            memWByte_q    <= memWByte_d;
            memWAddr_q    <= memWAddr_d;
            memWData_q    <= memWData_d;
        end
    end

    assign ic_valid_o         = icValid_q;
    assign ic_data_o          = icData_q;
    assign dc_valid_o         = dcValid_q;
    assign dc_data_o          = dcData_q;
    assign wr_ack_o           = wrAck_q;
    assign mem_read_o         = memRead_q;
    assign mem_read_addr_o    = memReadAddr_q;
    assign mem_write_enable_o = memWe_q;
    assign mem_write_byte_o   = memWByte_q;
    assign mem_write_addr_o   = memWAddr_q;
    assign mem_write_data_o   = memWData_q;

endmodule
